punc_control: RTL and testbench

- FSM controller for the PUnC LC3 core; the other end of the PUnC datapath control interface.
- Consumes the datapath's registered `ir` and drives every datapath control strobe and mux select.
- Sequences INIT, FETCH, DECODE, EXECUTE, optional second and CC-fix cycles, and HALT.

---
 rtl/punc_pkg.sv | 96 +++++++++
 rtl/punc_control_if.sv | 51 +++++
 rtl/punc_ctrl_decode.sv | 156 +++++++++++++++
 rtl/punc_control.sv | 91 +++++++++
 tb/tb_punc_control.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/punc_pkg.sv
// ============================================================================
// Module   : punc_pkg
// Brief    : Shared opcodes, state encoding and control-select codes for the
//            PUnC LC3 controller. Optional feature macro: LOAD_CC_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package punc_pkg;

    localparam logic [3:0] OC_BR   = 4'b0000;
    localparam logic [3:0] OC_ADD  = 4'b0001;
    localparam logic [3:0] OC_LD   = 4'b0010;
    localparam logic [3:0] OC_ST   = 4'b0011;
    localparam logic [3:0] OC_JSR  = 4'b0100;
    localparam logic [3:0] OC_AND  = 4'b0101;
    localparam logic [3:0] OC_LDR  = 4'b0110;
    localparam logic [3:0] OC_STR  = 4'b0111;
    localparam logic [3:0] OC_RTI  = 4'b1000;
    localparam logic [3:0] OC_NOT  = 4'b1001;
    localparam logic [3:0] OC_LDI  = 4'b1010;
    localparam logic [3:0] OC_STI  = 4'b1011;
    localparam logic [3:0] OC_JMP  = 4'b1100;
    localparam logic [3:0] OC_RES  = 4'b1101;
    localparam logic [3:0] OC_LEA  = 4'b1110;
    localparam logic [3:0] OC_TRAP = 4'b1111;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_EXEC2   = 3'd4,
`ifdef LOAD_CC_EN
        ST_CCFIX   = 3'd5,
`endif
        ST_HALT    = 3'd6
    } state_t;

    localparam logic [1:0] ALU_PASS = 2'd0;
    localparam logic [1:0] ALU_ADD  = 2'd1;
    localparam logic [1:0] ALU_AND  = 2'd2;
    localparam logic [1:0] ALU_NOT  = 2'd3;

    localparam logic [2:0] MRA_PC       = 3'd0;
    localparam logic [2:0] MRA_PC_ADDER = 3'd1;
    localparam logic [2:0] MRA_INDIRECT = 3'd2;
    localparam logic [2:0] MRA_MEM_DATA = 3'd3;
    localparam logic [2:0] MRA_ALU_C    = 3'd4;

    localparam logic [1:0] WDS_ALU_C    = 2'd0;
    localparam logic [1:0] WDS_PC       = 2'd1;
    localparam logic [1:0] WDS_MEM_DATA = 2'd2;
    localparam logic [1:0] WDS_PC_ADDER = 2'd3;

    localparam logic [3:0] SEXT_IMM5  = 4'b1000;
    localparam logic [3:0] SEXT_OFF6  = 4'b0100;
    localparam logic [3:0] SEXT_OFF9  = 4'b0010;
    localparam logic [3:0] SEXT_OFF11 = 4'b0001;

    typedef struct packed {
        logic        mem_wr_en;
        logic [2:0]  mem_r_addr_sel;
        logic        state2_STI;
        logic        STR;
        logic [2:0]  RF_wr_addr;
        logic        RF_wr_en;
        logic [2:0]  RF_r_addr_0;
        logic [2:0]  RF_r_addr_1;
        logic [1:0]  RF_w_data_sel;
        logic        ir_ld;
        logic        JMP_RET_JSRR;
        logic        pc_ld;
        logic        pc_clr;
        logic        pc_up;
        logic        add_const;
        logic [1:0]  alu_sel;
        logic        cc_en;
        logic        n;
        logic        z;
        logic        p;
        logic [10:0] const_n;
        logic [3:0]  SEXT_Select;
        logic        halted;
    } ctrl_t;

`ifdef LOAD_CC_EN
    // Loads whose CC update is deferred to the CCFIX cycle (LDI handled in EXEC2).
    function automatic logic is_load_op(input logic [3:0] op);
        return (op == OC_LD) || (op == OC_LDR) || (op == OC_LEA);
    endfunction
`endif

endpackage

`default_nettype wire

// File: rtl/punc_control_if.sv
// ============================================================================
// Module   : punc_control_if
// Brief    : Controller <-> datapath control bus (ir in, strobes/selects out).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface punc_control_if;
    logic [15:0] ir;
    logic        mem_wr_en;
    logic [2:0]  mem_r_addr_sel;
    logic        state2_STI;
    logic        STR;
    logic [2:0]  RF_wr_addr;
    logic        RF_wr_en;
    logic [2:0]  RF_r_addr_0;
    logic [2:0]  RF_r_addr_1;
    logic [1:0]  RF_w_data_sel;
    logic        ir_ld;
    logic        JMP_RET_JSRR;
    logic        pc_ld;
    logic        pc_clr;
    logic        pc_up;
    logic        add_const;
    logic [1:0]  alu_sel;
    logic        cc_en;
    logic        n;
    logic        z;
    logic        p;
    logic [10:0] const_n;
    logic [3:0]  SEXT_Select;
    logic        halted;

    modport master (
        input  ir,
        output mem_wr_en, mem_r_addr_sel, state2_STI, STR, RF_wr_addr, RF_wr_en,
               RF_r_addr_0, RF_r_addr_1, RF_w_data_sel, ir_ld, JMP_RET_JSRR,
               pc_ld, pc_clr, pc_up, add_const, alu_sel, cc_en, n, z, p,
               const_n, SEXT_Select, halted
    );

    modport slave (
        output ir,
        input  mem_wr_en, mem_r_addr_sel, state2_STI, STR, RF_wr_addr, RF_wr_en,
               RF_r_addr_0, RF_r_addr_1, RF_w_data_sel, ir_ld, JMP_RET_JSRR,
               pc_ld, pc_clr, pc_up, add_const, alu_sel, cc_en, n, z, p,
               const_n, SEXT_Select, halted
    );
endinterface

`default_nettype wire

// File: rtl/punc_ctrl_decode.sv
// ============================================================================
// Module   : punc_ctrl_decode
// Brief    : Combinational (state, ir) -> datapath control mapping.
//            Optional feature macro: LOAD_CC_EN (adds CCFIX decode).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module punc_ctrl_decode
    import punc_pkg::*;
#(
    parameter logic [3:0] HALT_OPC = 4'b1111
) (
    input  state_t      state,
    input  logic [15:0] ir,
    output ctrl_t       ctrl
);

    logic [3:0] w_op;
    logic [2:0] w_dr;
    logic [2:0] w_sr1;

    assign w_op  = ir[15:12];
    assign w_dr  = ir[11:9];
    assign w_sr1 = ir[8:6];

    always_comb begin
        ctrl         = '0;
        ctrl.const_n = ir[10:0];
        case (state)
            ST_INIT: ctrl.pc_clr = 1'b1;
            ST_FETCH: begin
                ctrl.mem_r_addr_sel = MRA_PC;
                ctrl.ir_ld          = 1'b1;
                ctrl.pc_up          = 1'b1;
            end
            ST_EXECUTE: begin
                if (w_op != HALT_OPC) begin
                    case (w_op)
                        OC_ADD, OC_AND: begin
                            ctrl.RF_r_addr_0   = w_sr1;
                            ctrl.RF_r_addr_1   = ir[2:0];
                            ctrl.add_const     = ir[5];
                            ctrl.SEXT_Select   = SEXT_IMM5;
                            ctrl.alu_sel       = (w_op == OC_ADD) ? ALU_ADD : ALU_AND;
                            ctrl.RF_wr_addr    = w_dr;
                            ctrl.RF_wr_en      = 1'b1;
                            ctrl.RF_w_data_sel = WDS_ALU_C;
                            ctrl.cc_en         = 1'b1;
                        end
                        OC_NOT: begin
                            ctrl.RF_r_addr_0   = w_sr1;
                            ctrl.alu_sel       = ALU_NOT;
                            ctrl.RF_wr_addr    = w_dr;
                            ctrl.RF_wr_en      = 1'b1;
                            ctrl.RF_w_data_sel = WDS_ALU_C;
                            ctrl.cc_en         = 1'b1;
                        end
                        OC_BR: begin
                            {ctrl.n, ctrl.z, ctrl.p} = ir[11:9];
                            ctrl.SEXT_Select         = SEXT_OFF9;
                        end
                        OC_JMP: begin
                            ctrl.RF_r_addr_0  = w_sr1;
                            ctrl.alu_sel      = ALU_PASS;
                            ctrl.JMP_RET_JSRR = 1'b1;
                            ctrl.pc_ld        = 1'b1;
                        end
                        OC_JSR: begin
                            // R7 captures the pre-jump PC on the same edge that loads PC.
                            ctrl.RF_wr_addr    = 3'd7;
                            ctrl.RF_w_data_sel = WDS_PC;
                            ctrl.RF_wr_en      = 1'b1;
                            ctrl.pc_ld         = 1'b1;
                            if (ir[11]) begin
                                ctrl.SEXT_Select = SEXT_OFF11;
                            end else begin
                                ctrl.JMP_RET_JSRR = 1'b1;
                                ctrl.RF_r_addr_0  = w_sr1;
                                ctrl.alu_sel      = ALU_PASS;
                            end
                        end
                        OC_LD: begin
                            ctrl.mem_r_addr_sel = MRA_PC_ADDER;
                            ctrl.SEXT_Select    = SEXT_OFF9;
                            ctrl.RF_w_data_sel  = WDS_MEM_DATA;
                            ctrl.RF_wr_addr     = w_dr;
                            ctrl.RF_wr_en       = 1'b1;
                        end
                        OC_LDR: begin
                            ctrl.mem_r_addr_sel = MRA_ALU_C;
                            ctrl.RF_r_addr_0    = w_sr1;
                            ctrl.add_const      = 1'b1;
                            ctrl.SEXT_Select    = SEXT_OFF6;
                            ctrl.alu_sel        = ALU_ADD;
                            ctrl.RF_w_data_sel  = WDS_MEM_DATA;
                            ctrl.RF_wr_addr     = w_dr;
                            ctrl.RF_wr_en       = 1'b1;
                        end
                        OC_LEA: begin
                            ctrl.SEXT_Select   = SEXT_OFF9;
                            ctrl.RF_w_data_sel = WDS_PC_ADDER;
                            ctrl.RF_wr_addr    = w_dr;
                            ctrl.RF_wr_en      = 1'b1;
                        end
                        OC_ST: begin
                            ctrl.RF_r_addr_0 = w_dr;
                            ctrl.alu_sel     = ALU_PASS;
                            ctrl.SEXT_Select = SEXT_OFF9;
                            ctrl.mem_wr_en   = 1'b1;
                        end
                        OC_STR: begin
                            ctrl.STR         = 1'b1;
                            ctrl.RF_r_addr_0 = w_sr1;
                            ctrl.RF_r_addr_1 = w_dr;
                            ctrl.add_const   = 1'b1;
                            ctrl.SEXT_Select = SEXT_OFF6;
                            ctrl.alu_sel     = ALU_ADD;
                            ctrl.mem_wr_en   = 1'b1;
                        end
                        OC_LDI, OC_STI: begin
                            ctrl.mem_r_addr_sel = MRA_PC_ADDER;
                            ctrl.SEXT_Select    = SEXT_OFF9;
                        end
                        default: ;
                    endcase
                end
            end
            ST_EXEC2: begin
                if (w_op == OC_LDI) begin
                    ctrl.mem_r_addr_sel = MRA_INDIRECT;
                    ctrl.RF_w_data_sel  = WDS_MEM_DATA;
                    ctrl.RF_wr_addr     = w_dr;
                    ctrl.RF_wr_en       = 1'b1;
                end else if (w_op == OC_STI) begin
                    ctrl.state2_STI  = 1'b1;
                    ctrl.RF_r_addr_0 = w_dr;
                    ctrl.alu_sel     = ALU_PASS;
                    ctrl.mem_wr_en   = 1'b1;
                end
            end
`ifdef LOAD_CC_EN
            ST_CCFIX: begin
                ctrl.RF_r_addr_0 = w_dr;
                ctrl.alu_sel     = ALU_PASS;
                ctrl.cc_en       = 1'b1;
            end
`endif
            ST_HALT: ctrl.halted = 1'b1;
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/punc_control.sv
// ============================================================================
// Module   : punc_control
// Brief    : PUnC LC3 controller FSM; drives the datapath control bus.
//            Optional feature macro: LOAD_CC_EN (CC update after loads).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module punc_control
    import punc_pkg::*;
#(
    parameter logic [3:0] HALT_OPC = 4'b1111
) (
    input  logic             clk,
    input  logic             rst,
    punc_control_if.master   bus
);

    state_t     r_state;
    ctrl_t      w_ctrl;
    logic [3:0] w_op;

    assign w_op = bus.ir[15:12];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_INIT;
        end else begin
            case (r_state)
                ST_INIT:   r_state <= ST_FETCH;
                ST_FETCH:  r_state <= ST_DECODE;
                ST_DECODE: r_state <= ST_EXECUTE;
                ST_EXECUTE: begin
                    if (w_op == HALT_OPC)
                        r_state <= ST_HALT;
                    else if ((w_op == OC_LDI) || (w_op == OC_STI))
                        r_state <= ST_EXEC2;
`ifdef LOAD_CC_EN
                    else if (is_load_op(w_op))
                        r_state <= ST_CCFIX;
`endif
                    else
                        r_state <= ST_FETCH;
                end
`ifdef LOAD_CC_EN
                ST_EXEC2:  r_state <= (w_op == OC_LDI) ? ST_CCFIX : ST_FETCH;
                ST_CCFIX:  r_state <= ST_FETCH;
`else
                ST_EXEC2:  r_state <= ST_FETCH;
`endif
                ST_HALT:   r_state <= ST_HALT;
                default:   r_state <= ST_INIT;
            endcase
        end
    end

    punc_ctrl_decode #(
        .HALT_OPC (HALT_OPC)
    ) u_decode (
        .state (r_state),
        .ir    (bus.ir),
        .ctrl  (w_ctrl)
    );

    assign bus.mem_wr_en      = w_ctrl.mem_wr_en;
    assign bus.mem_r_addr_sel = w_ctrl.mem_r_addr_sel;
    assign bus.state2_STI     = w_ctrl.state2_STI;
    assign bus.STR            = w_ctrl.STR;
    assign bus.RF_wr_addr     = w_ctrl.RF_wr_addr;
    assign bus.RF_wr_en       = w_ctrl.RF_wr_en;
    assign bus.RF_r_addr_0    = w_ctrl.RF_r_addr_0;
    assign bus.RF_r_addr_1    = w_ctrl.RF_r_addr_1;
    assign bus.RF_w_data_sel  = w_ctrl.RF_w_data_sel;
    assign bus.ir_ld          = w_ctrl.ir_ld;
    assign bus.JMP_RET_JSRR   = w_ctrl.JMP_RET_JSRR;
    assign bus.pc_ld          = w_ctrl.pc_ld;
    assign bus.pc_clr         = w_ctrl.pc_clr;
    assign bus.pc_up          = w_ctrl.pc_up;
    assign bus.add_const      = w_ctrl.add_const;
    assign bus.alu_sel        = w_ctrl.alu_sel;
    assign bus.cc_en          = w_ctrl.cc_en;
    assign bus.n              = w_ctrl.n;
    assign bus.z              = w_ctrl.z;
    assign bus.p              = w_ctrl.p;
    assign bus.const_n        = w_ctrl.const_n;
    assign bus.SEXT_Select    = w_ctrl.SEXT_Select;
    assign bus.halted         = w_ctrl.halted;

endmodule

`default_nettype wire

// File: tb/tb_punc_control.sv
// ============================================================================
// Module   : tb_punc_control
// Brief    : Directed-vector self-checking bench for punc_control.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_punc_control;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    punc_control_if bus ();

    punc_control dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_fetch(input string tag);
        check_value({tag, "_ir_ld"}, 32'(bus.ir_ld), 32'd1);
        check_value({tag, "_pc_up"}, 32'(bus.pc_up), 32'd1);
        check_value({tag, "_mra"}, 32'(bus.mem_r_addr_sel), 32'd0);
    endtask

    task automatic check_idle(input string tag);
        check_value({tag, "_idle"},
                    32'({bus.ir_ld, bus.pc_up, bus.pc_clr, bus.pc_ld, bus.RF_wr_en,
                         bus.mem_wr_en, bus.cc_en, bus.n, bus.z, bus.p, bus.halted}),
                    32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        bus.ir   = 16'h0000;

        // Reset / INIT
        repeat (3) tick();
        check_value("init_pc_clr", 32'(bus.pc_clr), 32'd1);
        check_value("init_halted", 32'(bus.halted), 32'd0);
        check_value("init_ir_ld", 32'(bus.ir_ld), 32'd0);
        #2 rst = 1'b1;
        tick();
        check_fetch("fetch0");
        check_value("fetch0_pc_clr", 32'(bus.pc_clr), 32'd0);
        check_value("fetch0_halted", 32'(bus.halted), 32'd0);

        // ADD R1,R1,#2
        bus.ir = 16'h1262;
        tick();
        check_idle("add_decode");
        tick();
        check_value("add_const", 32'(bus.add_const), 32'd1);
        check_value("add_sext", 32'(bus.SEXT_Select), 32'h8);
        check_value("add_alu", 32'(bus.alu_sel), 32'd1);
        check_value("add_wr_addr", 32'(bus.RF_wr_addr), 32'd1);
        check_value("add_wr_en", 32'(bus.RF_wr_en), 32'd1);
        check_value("add_cc_en", 32'(bus.cc_en), 32'd1);
        check_value("add_r0", 32'(bus.RF_r_addr_0), 32'd1);
        check_value("add_r1", 32'(bus.RF_r_addr_1), 32'd2);
        check_value("add_const_n", 32'(bus.const_n), 32'h262);
        tick();
        check_fetch("add_next");

        // LDI R2
        bus.ir = 16'hA402;
        tick();
        tick();
        check_value("ldi_ex_mra", 32'(bus.mem_r_addr_sel), 32'd1);
        check_value("ldi_ex_sext", 32'(bus.SEXT_Select), 32'h2);
        check_value("ldi_ex_wr_en", 32'(bus.RF_wr_en), 32'd0);
        tick();
        check_value("ldi_e2_mra", 32'(bus.mem_r_addr_sel), 32'd2);
        check_value("ldi_e2_wds", 32'(bus.RF_w_data_sel), 32'd2);
        check_value("ldi_e2_wr_addr", 32'(bus.RF_wr_addr), 32'd2);
        check_value("ldi_e2_wr_en", 32'(bus.RF_wr_en), 32'd1);
        check_value("ldi_e2_ir_ld", 32'(bus.ir_ld), 32'd0);
        tick();
`ifdef LOAD_CC_EN
        check_value("ldi_ccfix_cc_en", 32'(bus.cc_en), 32'd1);
        check_value("ldi_ccfix_alu", 32'(bus.alu_sel), 32'd0);
        check_value("ldi_ccfix_r0", 32'(bus.RF_r_addr_0), 32'd2);
        check_value("ldi_ccfix_ir_ld", 32'(bus.ir_ld), 32'd0);
        tick();
`endif
        check_fetch("ldi_next");
        check_value("ldi_next_cc_en", 32'(bus.cc_en), 32'd0);

        // JSR PC+3
        bus.ir = 16'h4803;
        tick();
        tick();
        check_value("jsr_wr_addr", 32'(bus.RF_wr_addr), 32'd7);
        check_value("jsr_wds", 32'(bus.RF_w_data_sel), 32'd1);
        check_value("jsr_pc_ld", 32'(bus.pc_ld), 32'd1);
        check_value("jsr_wr_en", 32'(bus.RF_wr_en), 32'd1);
        check_value("jsr_sext", 32'(bus.SEXT_Select), 32'h1);
        check_value("jsr_jmp", 32'(bus.JMP_RET_JSRR), 32'd0);
        tick();
        check_fetch("jsr_next");

        // JSRR R2
        bus.ir = 16'h4080;
        tick();
        tick();
        check_value("jsrr_jmp", 32'(bus.JMP_RET_JSRR), 32'd1);
        check_value("jsrr_r0", 32'(bus.RF_r_addr_0), 32'd2);
        check_value("jsrr_wr_addr", 32'(bus.RF_wr_addr), 32'd7);
        check_value("jsrr_sext", 32'(bus.SEXT_Select), 32'h0);
        check_value("jsrr_alu", 32'(bus.alu_sel), 32'd0);
        tick();
        check_fetch("jsrr_next");

        // BRnp
        bus.ir = 16'h0A05;
        check_value("br_fetch_nzp", 32'({bus.n, bus.z, bus.p}), 32'd0);
        tick();
        check_value("br_decode_nzp", 32'({bus.n, bus.z, bus.p}), 32'd0);
        tick();
        check_value("br_ex_nzp", 32'({bus.n, bus.z, bus.p}), 32'b101);
        check_value("br_ex_sext", 32'(bus.SEXT_Select), 32'h2);
        check_value("br_ex_pc_ld", 32'(bus.pc_ld), 32'd0);
        tick();
        check_fetch("br_next");
        check_value("br_next_nzp", 32'({bus.n, bus.z, bus.p}), 32'd0);

        // STR R1,R2,#3
        bus.ir = 16'h7283;
        tick();
        tick();
        check_value("str_str", 32'(bus.STR), 32'd1);
        check_value("str_wr", 32'(bus.mem_wr_en), 32'd1);
        check_value("str_r0", 32'(bus.RF_r_addr_0), 32'd2);
        check_value("str_r1", 32'(bus.RF_r_addr_1), 32'd1);
        check_value("str_addc", 32'(bus.add_const), 32'd1);
        check_value("str_sext", 32'(bus.SEXT_Select), 32'h4);
        check_value("str_alu", 32'(bus.alu_sel), 32'd1);
        check_value("str_rf_wr", 32'(bus.RF_wr_en), 32'd0);
        tick();
        check_fetch("str_next");

        // STI R3, then asynchronous reset in EXEC2
        bus.ir = 16'hB602;
        tick();
        tick();
        check_value("sti_ex_mra", 32'(bus.mem_r_addr_sel), 32'd1);
        check_value("sti_ex_wr", 32'(bus.mem_wr_en), 32'd0);
        tick();
        check_value("sti_e2_state2", 32'(bus.state2_STI), 32'd1);
        check_value("sti_e2_wr", 32'(bus.mem_wr_en), 32'd1);
        check_value("sti_e2_r0", 32'(bus.RF_r_addr_0), 32'd3);
        #2 rst = 1'b0;
        #1;
        check_value("sti_rst_wr", 32'(bus.mem_wr_en), 32'd0);
        check_value("sti_rst_state2", 32'(bus.state2_STI), 32'd0);
        check_value("sti_rst_pc_clr", 32'(bus.pc_clr), 32'd1);
        tick();
        check_value("sti_rst_hold_pc_clr", 32'(bus.pc_clr), 32'd1);
        #2 rst = 1'b1;
        tick();
        check_fetch("rst_fetch");

        // TRAP -> HALT
        bus.ir = 16'hF025;
        tick();
        tick();
        check_idle("halt_ex");
        for (int i = 0; i < 20; i++) begin
            tick();
            check_value("halt_halted", 32'(bus.halted), 32'd1);
            check_value("halt_ir_ld", 32'(bus.ir_ld), 32'd0);
        end
        #2 rst = 1'b0;
        #1;
        check_value("halt_rst_halted", 32'(bus.halted), 32'd0);
        check_value("halt_rst_pc_clr", 32'(bus.pc_clr), 32'd1);
        tick();
        #2 rst = 1'b1;
        tick();
        check_fetch("halt_rst_fetch");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
